// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller.
// One full-adder cell (two half adders plus an OR) is stepped over WIDTH
// clock cycles, LSB first, to add two WIDTH-bit operands.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a-b.
//
// Handshake: 'start' is sampled only in IDLE; the accepting edge captures a/b.
// 'busy' is high in RUN and DONE; 'done' is a one-cycle pulse in DONE, the
// only cycle in which sum/cout are first guaranteed valid. sum/cout then hold
// until the next accept. start while busy is dropped, never queued.

// Half adder: s = x ^ y, c = x & y.
module serial_adder_half (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

// Full adder cell built from two half adders and an OR gate.
module serial_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic s1, c1, c2;

  serial_adder_half u_ha0 (
    .x_i (a_i),
    .y_i (b_i),
    .s_o (s1),
    .c_o (c1)
  );

  serial_adder_half u_ha1 (
    .x_i (s1),
    .y_i (c_i),
    .s_o (s_o),
    .c_o (c2)
  );

  assign c_o = c1 | c2;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  // Counter only has to reach WIDTH-1 while in RUN; sized to hold WIDTH so
  // the final increment on the last bit never wraps.
  localparam int CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q,  sum_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q,  cout_d;

  logic             accept;
  logic             last_bit;
  logic             cell_s;
  logic             cell_c;
  logic             sub_mode;
  logic [WIDTH-1:0] b_load;
  logic [WIDTH-1:0] sum_shift;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1: invert B on load and seed the carry with 1.
  assign sub_mode = sub;
`else
  assign sub_mode = 1'b0;
`endif

  assign b_load   = sub_mode ? ~b : b;
  assign accept   = (state_q == ST_IDLE) && start;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  serial_adder_cell u_cell (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (cell_s),
    .c_o (cell_c)
  );

  // New result bit enters at the MSB so that after WIDTH steps bit 0 of the
  // operands has landed in sum[0].
  if (WIDTH == 1) begin : g_shift_w1
    assign sum_shift = cell_s;
  end else begin : g_shift_wn
    assign sum_shift = {cell_s, sum_q[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after last bit,
  // DONE -> IDLE unconditionally.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)    state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: load on accept, shift one bit per RUN cycle,
  // hold otherwise so the result persists through IDLE.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b_load;
      carry_d = sub_mode;
      cnt_d   = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
    end else if (state_q == ST_RUN) begin
      a_sh_d  = a_sh_q >> 1;
      b_sh_d  = b_sh_q >> 1;
      carry_d = cell_c;
      cnt_d   = cnt_q + CNT_W'(1);
      sum_d   = sum_shift;
      if (last_bit) begin
        cout_d = cell_c;
      end
    end
  end

  // Datapath registers; all clear on asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=8). Define SERIAL_ADDER_SUB_EN to
// also exercise the subtract mode.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub_r;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [1:0]   dbg_state;

  int n_cmp;
  int n_err;

  // Expected {cout, sum} per accepted operation.
  logic [W:0] exp_q[$];
  logic [W:0] last_res;
  int         mdl_left;   // busy cycles still to come; 1 means the done cycle
  bit         mon_en;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub_r),
`endif
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .dbg_state (dbg_state)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference timing model: an accept in idle starts W+1 busy cycles, the
  // last of which is the done cycle. The expected result is formed from the
  // operands the bench is driving at the accepting edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_left <= 0;
      last_res <= '0;
      exp_q.delete();
    end else if (mdl_left == 0) begin
      if (start) begin
        mdl_left <= W + 1;
        if (sub_r) exp_q.push_back({1'b0, a} + {1'b0, ~b} + 9'd1);
        else       exp_q.push_back({1'b0, a} + {1'b0, b});
      end
    end else begin
      mdl_left <= mdl_left - 1;
    end
  end

  // Scoreboard / monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check_eq("busy", busy, (mdl_left > 0));
      check_eq("done", done, (mdl_left == 1));
      if (done || mdl_left == 1) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_done", 1, 0);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check_eq("sum", sum, e[W-1:0]);
          check_eq("cout", cout, e[W]);
          last_res = e;
        end
      end else if (mdl_left == 0) begin
        check_eq("hold_result", {cout, sum}, last_res);
      end
    end
  end

  // Driver tasks.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    @(negedge clk);
    a     = av;
    b     = bv;
    sub_r = sv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom_range(0, 255);
    b     = $urandom_range(0, 255);
  endtask

  task automatic wait_idle(input int max_cycles);
    int i;
    for (i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (mdl_left == 0 && !busy) break;
    end
    if (i == max_cycles) check_eq("idle_timeout", 1, 0);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    mon_en = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    sub_r  = 1'b0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_sum",  sum,  0);
    check_eq("rst_cout", cout, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    mon_en = 1'b1;

    issue(8'h0F, 8'h01, 1'b0); wait_idle(40);
    issue(8'hFF, 8'h01, 1'b0); wait_idle(40);
    issue(8'hFF, 8'hFF, 1'b0); wait_idle(40);
    issue(8'h00, 8'h00, 1'b0); wait_idle(40);

    // start pulsed during RUN must be ignored.
    issue(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(40);

    // Reset in the 4th RUN cycle aborts with no done pulse.
    issue(8'hAA, 8'h55, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_sum",  sum,  0);
    check_eq("abort_cout", cout, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    issue(8'h01, 8'h02, 1'b0); wait_idle(40);

    // start held high: back-to-back runs every W+2 cycles.
    @(negedge clk);
    a = 8'h80; b = 8'h80; sub_r = 1'b0; start = 1'b1;
    repeat (30) @(negedge clk);
    start = 1'b0;
    wait_idle(40);

    // A few random additions.
    for (int k = 0; k < 6; k++) begin
      issue(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b0);
      wait_idle(40);
    end

`ifdef SERIAL_ADDER_SUB_EN
    issue(8'h05, 8'h07, 1'b1); wait_idle(40);
    issue(8'h07, 8'h05, 1'b1); wait_idle(40);
    for (int k = 0; k < 4; k++) begin
      issue(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b1);
      wait_idle(40);
    end
    sub_r = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It sequences a single 1-bit adder cell over WIDTH clock cycles to add two WIDTH-bit operands, LSB first. The cell is two half adders plus an OR gate, instantiated inside the block. The block provides the arithmetic library's area-minimal multi-bit adder, with a start/busy/done handshake toward the issuing logic.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin an addition; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepting edge
b  input  WIDTH  operand B; captured on the accepting edge
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  result; held until the next accepted start
cout  output  1  carry out of the MSB; held with sum

Behaviour:
- Reset: asynchronous on rst_n low. All of the following clear immediately:
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0
  - internal operand shift registers, bit counter and carry flop = 0
- States:
  - IDLE -> RUN on a clk edge with start=1.
  - RUN -> DONE on the edge that processes bit WIDTH-1.
  - DONE -> IDLE unconditionally on the next edge.
- Accept, at edge k (IDLE, start=1):
  - latch a and b into shift registers
  - count=0, carry flop=0
  - clear sum to 0
  - busy rises after edge k
- RUN, each edge:
  - cell computes s = a_sh[0]^b_sh[0]^carry and c = (a_sh[0]&b_sh[0]) | (carry&(a_sh[0]^b_sh[0])).
  - s shifts into sum from the MSB side (sum <= {s, sum[WIDTH-1:1]}).
  - a_sh and b_sh shift right by one; carry <= c; count++.
- Latency:
  - bit WIDTH-1 is processed at edge k+WIDTH
  - DONE occupies the cycle after edge k+WIDTH; done=1 there
  - sum holds the full result and cout holds the final carry in that cycle
- done is high only in DONE. busy=0 again after edge k+WIDTH+1.
- sum and cout:
  - in RUN, sum holds a partial shifted value; consumers must use it only when done=1 or in IDLE after done
  - after DONE, sum and cout hold their values until the next accept
- start in RUN or DONE is ignored, with no queuing. Operand changes after accept have no effect.
- Minimum period between accepts: WIDTH+2 cycles (start held high continuously restarts on the first IDLE edge).
- Reset mid-operation aborts immediately, with no done pulse; the next start after rst_n deasserts runs normally.
- WIDTH=1: RUN lasts exactly one edge.
- Counter width: $clog2(WIDTH+1) bits; never wraps, because it leaves RUN at count=WIDTH-1.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - adds input port sub (1 bit), captured with the operands on accept
  - when sub=1: b_sh is loaded with ~b and the carry flop is initialised to 1, so sum = a-b mod 2^WIDTH and cout = 1 means no borrow
  - when sub=0: behaviour is identical to the undefined case
- Undefined: no sub port; addition only.

Test Plan:
- WIDTH=8, reset, a=8'h0F, b=8'h01, start for 1 cycle -> busy for 9 cycles; done pulses exactly once, 9 cycles after the accept edge; sum=8'h10, cout=0.
- a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1. Then a=0, b=0 -> sum=0, cout=0.
- Accept a=8'h12, b=8'h34; pulse start again in the 3rd RUN cycle with a=8'hFF, b=8'hFF -> ignored; done once; sum=8'h46, cout=0.
- Accept a=8'hAA, b=8'h55; drop rst_n in the 4th RUN cycle -> busy, done, sum and cout go to 0 immediately with no done pulse. Release reset, then a=8'h01, b=8'h02 -> sum=8'h03.
- start held high for 30 cycles with a=8'h80, b=8'h80 -> back-to-back runs every 10 cycles; each gives sum=8'h00, cout=1, with done high exactly 1 cycle per run.
- SERIAL_ADDER_SUB_EN defined, sub=1:
  - a=8'h05, b=8'h07 -> sum=8'hFE, cout=0
  - a=8'h07, b=8'h05 -> sum=8'h02, cout=1
